// File: rtl/branch_resolve_unit.sv
// In-order queue of predicted branches awaiting resolution from execute.
// Each resolve produces a BHT counter update and, on a mispredict, a flush and redirect.
module branch_resolve_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_valid,
   output logic        push_ready,
   input  logic [31:0] push_pc,
   input  logic [31:0] push_target,
   input  logic [1:0]  push_state,
   input  logic [4:0]  push_idx,
   input  logic        res_valid,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   output logic        upd_en,
   output logic [4:0]  upd_idx,
   output logic [1:0]  upd_state,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        empty,
   output logic        full,
   output logic [3:0]  count,
   output logic [15:0] br_cnt,
   output logic [15:0] mis_cnt,
   output logic        underflow
);
   localparam int            PW        = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE   = 1;
   localparam logic [3:0]    CNT_DEPTH = 4'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic [1:0]  state;
      logic [4:0]  idx;
   } br_entry_t;

   br_entry_t   mem_q [DEPTH];
   br_entry_t   mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]  count_q, count_d;
   logic        upd_en_q, upd_en_d;
   logic [4:0]  upd_idx_q, upd_idx_d;
   logic [1:0]  upd_state_q, upd_state_d;
   logic        flush_q, flush_d;
   logic [31:0] redirect_q, redirect_d;
   logic [15:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
   logic        underflow_q, underflow_d;

   br_entry_t   head;
   logic        push_fire, res_fire, pred, mispred;
   logic [1:0]  new_state;

   assign empty      = (count_q == 4'd0);
   assign full       = (count_q == CNT_DEPTH);
   assign push_ready = !full;
   assign count      = count_q;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      upd_idx_d   = upd_idx_q;
      upd_state_d = upd_state_q;
      redirect_d  = redirect_q;
      br_cnt_d    = br_cnt_q;
      mis_cnt_d   = mis_cnt_q;

      head      = mem_q[rd_ptr_q];
      push_fire = push_valid && !full;
      res_fire  = res_valid && !empty;
      pred      = head.state[1];

      if (res_taken) new_state = (head.state == 2'b11) ? 2'b11 : head.state + 2'd1;
      else           new_state = (head.state == 2'b00) ? 2'b00 : head.state - 2'd1;

      mispred = res_fire && ((res_taken != pred) ||
                             (res_taken && pred && (res_target != head.target)));

      if (push_fire) begin
         mem_d[wr_ptr_q] = '{pc: push_pc, target: push_target, state: push_state, idx: push_idx};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (res_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + {3'b000, push_fire} - {3'b000, res_fire};

      // A mispredict kills everything younger, including a same-cycle push.
      if (mispred) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = 4'd0;
      end

      upd_en_d = res_fire;
      if (res_fire) begin
         upd_idx_d   = head.idx;
         upd_state_d = new_state;
         if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
      end

      flush_d = mispred;
      if (mispred) begin
         redirect_d = res_taken ? res_target : head.pc + 32'd4;
         if (mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
      end

      underflow_d = res_valid && empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= 4'd0;
         upd_en_q    <= 1'b0;
         upd_idx_q   <= 5'd0;
         upd_state_q <= 2'd0;
         flush_q     <= 1'b0;
         redirect_q  <= 32'd0;
         br_cnt_q    <= 16'd0;
         mis_cnt_q   <= 16'd0;
         underflow_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         upd_en_q    <= upd_en_d;
         upd_idx_q   <= upd_idx_d;
         upd_state_q <= upd_state_d;
         flush_q     <= flush_d;
         redirect_q  <= redirect_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
         underflow_q <= underflow_d;
      end
   end

   assign upd_en      = upd_en_q;
   assign upd_idx     = upd_idx_q;
   assign upd_state   = upd_state_q;
   assign flush       = flush_q;
   assign redirect_pc = redirect_q;
   assign br_cnt      = br_cnt_q;
   assign mis_cnt     = mis_cnt_q;
   assign underflow   = underflow_q;
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of in-flight branch queue entries (power of 2, 2..8).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port push_valid  in  1  fetch offers a predicted branch.
REQ-005 SHALL have port push_ready  out  1  queue accepts a push this cycle.
REQ-006 SHALL have port push_pc  in  32  branch instruction PC.
REQ-007 SHALL have port push_target  in  32  predicted taken target.
REQ-008 SHALL have port push_state  in  2  2-bit counter state read from BHT at fetch.
REQ-009 SHALL have port push_idx  in  5  BHT index used at fetch.
REQ-010 SHALL have port res_valid  in  1  execute resolves the oldest branch.
REQ-011 SHALL have port res_taken  in  1  actual branch outcome.
REQ-012 SHALL have port res_target  in  32  actual taken target.
REQ-013 SHALL have ports upd_en out 1, upd_idx out 5, upd_state out 2: BHT write-back (new counter state).
REQ-014 SHALL have ports flush out 1 and redirect_pc out 32: mispredict kill and corrected fetch PC.
REQ-015 SHALL have ports empty out 1, full out 1, count out 4: queue occupancy.
REQ-016 SHALL have ports br_cnt out 16, mis_cnt out 16, underflow out 1: statistics and error pulse.

Function
REQ-017 SHALL hold branches in a FIFO of DEPTH entries {pc, target, state, idx}, resolved strictly oldest-first.
REQ-018 SHALL compute push_ready = !full combinationally; push fires on push_valid && push_ready.
REQ-019 SHALL NOT bypass when full: a push while full is refused even if a resolve fires that cycle.
REQ-020 SHALL fire a resolve on res_valid && !empty; res_valid while empty SHALL be ignored and pulse underflow for one cycle after the edge.
REQ-021 SHALL take the prediction of an entry as state[1] (00,01 not-taken; 10,11 taken).
REQ-022 SHALL compute the new state as a saturating counter: taken -> min(state+1,3); not-taken -> max(state-1,0).
REQ-023 SHALL register upd_en high for exactly one cycle after every resolve fire, with upd_idx = entry idx and upd_state = new state, even when unchanged.
REQ-024 SHALL declare a mispredict when res_taken != state[1], or when res_taken && state[1] && res_target != entry target.
REQ-025 SHALL, on mispredict, pulse flush one cycle after the resolve edge, with redirect_pc = res_target if taken else entry pc + 4 (32-bit wrap).
REQ-026 SHALL, on mispredict, empty the queue at the resolve edge; a push firing that same cycle SHALL be accepted by handshake and discarded.
REQ-027 SHALL hold redirect_pc at its last value when flush is low.
REQ-028 SHALL update count by +1 push, -1 resolve, 0 for both; pointers wrap modulo DEPTH.
REQ-029 SHALL increment br_cnt per resolve and mis_cnt per mispredict, each saturating at 0xFFFF.
REQ-030 SHALL never assert upd_en or flush without a preceding resolve fire.

Reset
REQ-031 SHALL, on rst_n low, immediately clear queue, pointers, count, br_cnt, mis_cnt, upd_en, upd_idx, upd_state, flush, redirect_pc, underflow to 0; empty=1, full=0.
REQ-032 SHALL discard all in-flight entries on reset mid-operation; no pending update or flush SHALL appear after release.

Verification
REQ-033 SHALL pass: push pc=0x100, state=01, then resolve taken, target 0x200 -> upd_en 1 cycle, upd_state=10, flush=1, redirect_pc=0x200, mis_cnt=1.
REQ-034 SHALL pass: push state=11, target 0x40, resolve taken target 0x40 -> upd_state=11, no flush; then state=00 resolve not-taken -> upd_state=00, no flush.
REQ-035 SHALL pass: 4 pushes -> full=1, push_ready=0; 5th push with simultaneous resolve refused; count 4->3.
REQ-036 SHALL pass: 3 queued, oldest state=10 pc=0x300 resolves not-taken with concurrent push -> flush, redirect_pc=0x304, count=0, empty=1.
REQ-037 SHALL pass: res_valid with empty queue -> underflow 1 cycle, no upd_en, counters unchanged.
REQ-038 SHALL pass: rst_n low mid-stream with 2 entries -> all outputs 0 asynchronously, empty=1 after release.
